// File: rtl/tick_scheduler.sv
// tick_scheduler: shared periodic-tick generator.
// A single free-running prescaler divides CLK into a base tick. NCH = 2**CHW
// independent channels count base ticks and each emits a one-cycle tick strobe,
// a 50% duty toggling clock, and a pending/ack handshake with a sticky overrun.
// Optional feature macro: TICK_SCHED_PRESYNC_EN -- when defined, every
// configuration write also restarts the prescaler, giving a phase-aligned
// first tick exactly period*PRESCALE cycles after the write edge.
module tick_scheduler #(
  parameter int PRESCALE = 100000,
  parameter int PSW      = 17,
  parameter int PW       = 16,
  parameter int CHW      = 2,
  localparam int NCH     = 2**CHW
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic           cfg_en,
  input  logic [NCH-1:0] ack,
  input  logic           clr_ovr,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clkout,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] overrun
);

  localparam logic [PSW-1:0] PCNT_LAST = PSW'(PRESCALE - 1);
  localparam logic [PSW-1:0] PCNT_ONE  = {{(PSW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]  PER_ONE   = {{(PW-1){1'b0}}, 1'b1};

  // Prescaler state
  logic [PSW-1:0] r_pcnt;
  logic [PSW-1:0] w_pcnt_nxt;
  logic           w_base_tick;
  logic           w_wr_resync;

  // Per-channel configuration and counting state
  logic [PW-1:0]  r_period [NCH];
  logic [PW-1:0]  r_cnt    [NCH];
  logic [NCH-1:0] r_en;
  logic [NCH-1:0] r_tick;
  logic [NCH-1:0] r_clkout;
  logic [NCH-1:0] r_pending;
  logic [NCH-1:0] r_overrun;

  // Per-channel decode
  logic [NCH-1:0] w_active;
  logic [NCH-1:0] w_wrsel;
  logic [NCH-1:0] w_term;
  logic [NCH-1:0] w_fire;
  logic [NCH-1:0] w_pend_nxt;
  logic [NCH-1:0] w_ovr_nxt;

  assign w_base_tick = (r_pcnt == PCNT_LAST);

`ifdef TICK_SCHED_PRESYNC_EN
  // A configuration write restarts the prescaler so the written channel's
  // phase is aligned to the write edge.
  assign w_wr_resync = cfg_wr;
`else
  // Prescaler runs freely regardless of configuration traffic.
  assign w_wr_resync = 1'b0;
`endif

  // Prescaler next value: wrap at PRESCALE-1 (or restart on a resync write).
  always_comb begin
    w_pcnt_nxt = r_pcnt;
    if (w_base_tick || w_wr_resync) begin
      w_pcnt_nxt = '0;
    end else begin
      w_pcnt_nxt = r_pcnt + PCNT_ONE;
    end
  end

  // Prescaler counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= w_pcnt_nxt;
    end
  end

  // Channel decode: activity, write select, terminal count and fire.
  // A write to a channel suppresses that channel's fire in the same cycle.
  always_comb begin
    w_active = '0;
    w_wrsel  = '0;
    w_term   = '0;
    w_fire   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_active[i] = r_en[i] && (r_period[i] != '0);
      w_wrsel[i]  = cfg_wr && (cfg_ch == CHW'(i));
      w_term[i]   = (r_cnt[i] == (r_period[i] - PER_ONE));
      w_fire[i]   = w_base_tick && w_active[i] && w_term[i] && !w_wrsel[i];
    end
  end

  // Channel counters, configuration registers, tick strobe and clkout.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NCH; i++) begin
        r_period[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_en     <= '0;
      r_tick   <= '0;
      r_clkout <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_wrsel[i]) begin
          // Write wins: reload config and restart the channel from zero.
          r_period[i] <= cfg_period;
          r_en[i]     <= cfg_en;
          r_cnt[i]    <= '0;
          r_clkout[i] <= 1'b0;
          r_tick[i]   <= 1'b0;
        end else if (!w_active[i]) begin
          // Inactive channel is parked; pending/overrun are kept elsewhere.
          r_cnt[i]    <= '0;
          r_clkout[i] <= 1'b0;
          r_tick[i]   <= 1'b0;
        end else if (w_base_tick) begin
          if (w_term[i]) begin
            r_cnt[i]    <= '0;
            r_tick[i]   <= 1'b1;
            r_clkout[i] <= ~r_clkout[i];
          end else begin
            r_cnt[i]    <= r_cnt[i] + PER_ONE;
            r_tick[i]   <= 1'b0;
          end
        end else begin
          r_tick[i]   <= 1'b0;
        end
      end
    end
  end

  // Handshake next state: a fire always (re)asserts pending; firing onto an
  // unacknowledged pending tick sets overrun, which beats clr_ovr.
  always_comb begin
    w_pend_nxt = r_pending;
    w_ovr_nxt  = r_overrun;
    for (int i = 0; i < NCH; i++) begin
      if (w_fire[i]) begin
        w_pend_nxt[i] = 1'b1;
        if (r_pending[i] && !ack[i]) begin
          w_ovr_nxt[i] = 1'b1;
        end else if (clr_ovr) begin
          w_ovr_nxt[i] = 1'b0;
        end else begin
          w_ovr_nxt[i] = r_overrun[i];
        end
      end else begin
        if (ack[i] && r_pending[i]) begin
          w_pend_nxt[i] = 1'b0;
        end else begin
          w_pend_nxt[i] = r_pending[i];
        end
        if (clr_ovr) begin
          w_ovr_nxt[i] = 1'b0;
        end else begin
          w_ovr_nxt[i] = r_overrun[i];
        end
      end
    end
  end

  // Pending and overrun registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_overrun <= w_ovr_nxt;
    end
  end

  assign tick    = r_tick;
  assign clkout  = r_clkout;
  assign pending = r_pending;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler (PRESCALE=4, PW=8, CHW=2).
// Table-driven period vectors with a queue of expected intervals, plus
// hand-written sequences for reset, overrun, ack/fire and write/base-tick
// collisions.
module tb_tick_scheduler;

  localparam int PRESCALE = 4;
  localparam int PSW      = 3;
  localparam int PW       = 8;
  localparam int CHW      = 2;
  localparam int NCH      = 4;
  localparam int NV       = 7;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           cfg_wr = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic           cfg_en = 1'b0;
  logic [NCH-1:0] ack = '0;
  logic           clr_ovr = 1'b0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clkout;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] overrun;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [1:0] ch;
    logic [7:0] period;
    logic       en;
    int         n_int;
    int         exp_int;   // expected tick interval in cycles, 0 = silent
  } vec_t;

  vec_t vt[NV];

  tick_scheduler #(
    .PRESCALE(PRESCALE),
    .PSW(PSW),
    .PW(PW),
    .CHW(CHW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_en(cfg_en),
    .ack(ack),
    .clr_ovr(clr_ovr),
    .tick(tick),
    .clkout(clkout),
    .pending(pending),
    .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    cfg_wr = 1'b0;
    ack = '0;
    clr_ovr = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // Write sampled at the posedge between two negedges; returns on the
  // negedge right after the write edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] p, input logic en);
    @(negedge CLK);
    cfg_wr = 1'b1;
    cfg_ch = ch;
    cfg_period = p;
    cfg_en = en;
    @(negedge CLK);
    cfg_wr = 1'b0;
  endtask

  // Count negedges until tick[ch] is seen high; -1 if the budget expires.
  task automatic wait_tick(input int ch, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLK);
      if (tick[ch]) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat;
  int seen;
  int clk_hi;
  int ch;
  int expv;

  initial begin
    vt[0] = '{2'd0, 8'd3,   1'b1, 3, 12};
    vt[1] = '{2'd1, 8'd1,   1'b1, 3, 4};
    vt[2] = '{2'd2, 8'd2,   1'b1, 2, 8};
    vt[3] = '{2'd3, 8'd5,   1'b1, 2, 20};
    vt[4] = '{2'd3, 8'd255, 1'b1, 1, 1020};
    vt[5] = '{2'd1, 8'd0,   1'b1, 0, 0};
    vt[6] = '{2'd2, 8'd3,   1'b0, 0, 0};

    // Reset state
    do_reset();
    chk("rst_tick", tick, 4'h0);
    chk("rst_clkout", clkout, 4'h0);
    chk("rst_pending", pending, 4'h0);
    chk("rst_overrun", overrun, 4'h0);

    // Table-driven period vectors
    for (int v = 0; v < NV; v++) begin
      do_reset();
      ch = vt[v].ch;
      cfg_write(vt[v].ch, vt[v].period, vt[v].en);
      if (vt[v].exp_int == 0) begin
        seen = 0;
        clk_hi = 0;
        repeat (200) begin
          @(negedge CLK);
          if (tick[ch]) seen++;
          if (clkout[ch]) clk_hi++;
        end
        chk("silent_ticks", seen, 0);
        chk("silent_clkout", clk_hi, 0);
      end else begin
        for (int n = 0; n < vt[v].n_int; n++) exp_q.push_back(vt[v].exp_int);
        wait_tick(ch, vt[v].exp_int + 8, lat);
`ifdef TICK_SCHED_PRESYNC_EN
        chk("first_latency", lat, vt[v].exp_int);
`else
        chk_range("first_latency", lat, vt[v].exp_int - PRESCALE + 1, vt[v].exp_int);
`endif
        chk("first_pending", pending[ch], 1'b1);
        chk("first_clkout", clkout[ch], 1'b1);
        for (int k = 1; k <= vt[v].n_int; k++) begin
          @(negedge CLK);
          chk("tick_width", tick[ch], 1'b0);
          wait_tick(ch, vt[v].exp_int + 8, lat);
          expv = exp_q.pop_front();
          chk("interval", lat + 1, expv);
          chk("clkout_toggle", clkout[ch], (k % 2 == 1) ? 1'b0 : 1'b1);
        end
        chk("overrun_no_ack", overrun[ch], 1'b1);
        chk("queue_drained", exp_q.size(), 0);
      end
    end

    // Asynchronous reset mid-operation
    do_reset();
    for (int c = 0; c < NCH; c++) cfg_write(c[1:0], 8'd1, 1'b1);
    repeat (12) @(negedge CLK);
    chk("pre_rst_pending", pending, 4'hF);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_tick", tick, 4'h0);
    chk("async_rst_clkout", clkout, 4'h0);
    chk("async_rst_pending", pending, 4'h0);
    chk("async_rst_overrun", overrun, 4'h0);
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge CLK);
      if (tick != 4'h0) seen++;
    end
    chk("post_rst_silent", seen, 0);

    // Overrun and clr_ovr (ch2, period 1, never acked)
    do_reset();
    cfg_write(2'd2, 8'd1, 1'b1);
    wait_tick(2, 12, lat);
    chk("ovr_first_pending", pending[2], 1'b1);
    chk("ovr_first_overrun", overrun[2], 1'b0);
    @(negedge CLK);
    wait_tick(2, 8, lat);
    chk("ovr_second_gap", lat + 1, 4);
    chk("ovr_set", overrun, 4'b0100);
    clr_ovr = 1'b1;
    @(negedge CLK);
    clr_ovr = 1'b0;
    chk("ovr_cleared", overrun[2], 1'b0);
    repeat (2) @(negedge CLK);
    clr_ovr = 1'b1;
    @(negedge CLK);
    clr_ovr = 1'b0;
    chk("ovr_set_wins_tick", tick[2], 1'b1);
    chk("ovr_set_wins", overrun[2], 1'b1);

    // Ack/fire collision (ch3, period 1)
    do_reset();
    cfg_write(2'd3, 8'd1, 1'b1);
    wait_tick(3, 12, lat);
    chk("ack_first_pending", pending[3], 1'b1);
    repeat (3) @(negedge CLK);
    ack = 4'b1000;
    @(negedge CLK);
    chk("ack_fire_tick", tick[3], 1'b1);
    chk("ack_fire_pending", pending[3], 1'b1);
    chk("ack_fire_overrun", overrun[3], 1'b0);
    @(negedge CLK);
    chk("ack_alone_pending", pending[3], 1'b0);
    @(negedge CLK);
    ack = 4'b0000;
    chk("ack_idle_pending", pending[3], 1'b0);
    chk("ack_idle_overrun", overrun[3], 1'b0);

    // Write/base_tick collision (ch0, period 2)
    do_reset();
    cfg_write(2'd0, 8'd2, 1'b1);
    wait_tick(0, 16, lat);
    chk("wrc_first_clkout", clkout[0], 1'b1);
    repeat (7) @(negedge CLK);
    cfg_wr = 1'b1;
    cfg_ch = 2'd0;
    cfg_period = 8'd2;
    cfg_en = 1'b1;
    @(negedge CLK);
    cfg_wr = 1'b0;
    chk("wrc_no_tick", tick[0], 1'b0);
    chk("wrc_clkout_cleared", clkout[0], 1'b0);
    chk("wrc_pending_kept", pending[0], 1'b1);
    wait_tick(0, 12, lat);
    chk("wrc_next_tick", lat, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Shared periodic-tick generator: one free-running prescaler divides the 100 MHz CLK into a base tick.
- 2**CHW independent channels count base ticks. Each channel emits a one-cycle tick strobe and a 50% duty toggling clock at its programmed period.
- Each tick is tracked with a pending/ack handshake and a sticky overrun flag.
- Replaces per-consumer clock dividers (e.g. the joystick 5 Hz send/receive clock) with one scheduled resource.

Parameters:
- PRESCALE, 100000, CLK cycles per base tick (1 kHz at 100 MHz); must be >= 2.
- PSW, 17, prescaler counter width; 2**PSW >= PRESCALE.
- PW, 16, channel period width, in base ticks.
- CHW, 2, channel index width; NCH = 2**CHW channels.

Ports:
- CLK  in  1  100 MHz system clock
- RST  in  1  asynchronous reset, active-low
- cfg_wr  in  1  configuration write strobe
- cfg_ch  in  CHW  channel being configured
- cfg_period  in  PW  period in base ticks; 0 = channel silent
- cfg_en  in  1  channel enable
- ack  in  NCH  per-channel acknowledge of a pending tick
- clr_ovr  in  1  clears all overrun flags
- tick  out  NCH  one-cycle tick strobe
- clkout  out  NCH  toggling clock level, flips on each tick
- pending  out  NCH  tick awaiting ack
- overrun  out  NCH  sticky: tick fired while pending

Behaviour:
- Reset (RST=0, async): prescaler, all channel counters, period/enable registers, tick, clkout, pending and overrun all go to 0. Outputs stay 0 until RST=1. Reset mid-operation discards all configuration.
- Prescaler: pcnt counts 0..PRESCALE-1 and wraps to 0. base_tick = (pcnt == PRESCALE-1), internal and combinational. The prescaler is never affected by configuration (except under the optional feature).
- Channel i is active when en[i]=1 and period[i] != 0.
- Counting on base_tick, active channel i:
  - If cnt[i] == period[i]-1: cnt[i] <= 0, tick[i] <= 1, clkout[i] <= ~clkout[i].
  - Otherwise: cnt[i] <= cnt[i]+1.
- tick[i] is registered and high for exactly one CLK cycle, in the cycle after the base_tick cycle.
- Steady-state rates: tick interval = period*PRESCALE cycles; clkout period = 2*period*PRESCALE cycles.
- Inactive channel: cnt held at 0, clkout forced to 0, no ticks. Pending and overrun are retained.
- Config write: when cfg_wr=1 at an edge, channel cfg_ch gets:
  - period <= cfg_period, en <= cfg_en
  - cnt <= 0, clkout <= 0, tick <= 0
- A write wins over a base_tick for the same channel in the same cycle; that channel's count and fire are lost. Other channels are unaffected.
- Period arithmetic is unsigned PW bits. Period 1 fires on every base tick. Max period is 2**PW-1.
- Handshake, per channel, evaluated at each edge (fire = tick being set this edge):
  - fire, no ack, pending=0: pending <= 1.
  - fire, no ack, pending=1: pending stays 1; overrun <= 1.
  - fire with ack while pending: pending stays 1 (new event); no overrun.
  - ack without fire while pending: pending <= 0.
  - ack while not pending: ignored.
- clr_ovr=1 clears every overrun bit. If an overrun is set in the same cycle, set wins for that channel.
- No combinational path from any input to any output.

Optional Feature:
- Macro: TICK_SCHED_PRESYNC_EN.
- Defined: any config write also resets pcnt to 0 at the same edge. The first tick of the written channel is then exactly period*PRESCALE cycles after the write edge (phase-aligned restart). Other channels' phases shift accordingly.
- Undefined: the prescaler is untouched by writes. First-tick latency after a write lies between (period-1)*PRESCALE+1 and period*PRESCALE cycles.

Test Plan (PRESCALE=4, PW=8, CHW=2):
- Reset: run traffic, drive RST=0 asynchronously mid-cycle -> tick/clkout/pending/overrun all 0 before the next CLK edge; no ticks until reconfigured.
- Period: write ch0 period=3, en=1 (PRESYNC defined) -> tick[0] high 1 cycle, first pulse 12 cycles after write edge, then every 12 cycles; clkout[0] period 24 cycles, 50% duty.
- Period 0: write ch1 period=0, en=1 -> tick[1]=0, clkout[1]=0 over 200 cycles.
- Overrun: ch2 period=1, never ack -> pending[2]=1 after first tick, overrun[2]=1 after second; pulse clr_ovr -> overrun[2]=0, set again at next tick.
- Ack/fire collision: ch3 period=1; assert ack[3] in the exact cycle of the next fire -> pending[3] remains 1, overrun[3] remains 0; ack alone next cycle -> pending[3]=0.
- Write/base_tick collision: ch0 running period=2; write ch0 period=2 on a base_tick cycle -> no tick that cycle, cnt restarts, next tick after 2 further base ticks.
